chacha20_session_arbiter: RTL
=============================

Name: chacha20_session_arbiter

Overview:
Shares one chacha20_encrypt core between N_CH independent requester channels. Each channel supplies its own key, nonce and initial counter, plus a plaintext/ciphertext stream. Grants are round-robin, one whole message (start to done) per grant. The arbiter latches the granted context, sequences the core's start pulse, and muxes and demuxes the streaming handshakes. It sits between the channel front-ends and the single core instance.

Parameters:
N_CH, 4, number of requester channels (2..8)
DATA_WIDTH_WORDS, 1, stream width in 32-bit words; must match the core
IDX_W, $clog2(N_CH), width of the grant index

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ch_req  in  N_CH  per-channel session request (level)
ch_key  in  N_CH*256  per-channel key, channel i at [i*256 +: 256]
ch_nonce  in  N_CH*96  per-channel nonce
ch_counter  in  N_CH*32  per-channel initial block counter
ch_pt_data  in  N_CH*32*DATA_WIDTH_WORDS  plaintext
ch_pt_valid  in  N_CH  plaintext valid
ch_pt_last  in  N_CH  last plaintext beat
ch_pt_ready  out  N_CH  plaintext ready
ch_ct_data  out  32*DATA_WIDTH_WORDS  ciphertext, shared bus
ch_ct_valid  out  N_CH  ciphertext valid, per channel
ch_ct_last  out  1  last ciphertext beat
ch_ct_ready  in  N_CH  downstream ready
ch_grant  out  N_CH  one-hot current grant
ch_done  out  N_CH  one-cycle session-complete pulse
core_start  out  1  start pulse to core
core_key/core_nonce/core_counter  out  256/96/32  latched context to core
core_pt_data/core_pt_valid/core_pt_last  out  32*DATA_WIDTH_WORDS/1/1  to core
core_pt_ready  in  1  from core
core_ct_data/core_ct_valid/core_ct_last  in  32*DATA_WIDTH_WORDS/1/1  from core
core_ct_ready  out  1  to core
core_done  in  1  core completion pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = N_CH-1, so channel 0 is served first.
- States and transitions:
  - IDLE: if any ch_req, pick the first requester scanning from last_grant+1 with wrap modulo N_CH. Register grant_idx, set ch_grant, latch key/nonce/counter into context regs, go START.
  - START: core_start=1 for exactly one cycle, go STREAM.
  - STREAM:
    - core_pt_* = channel g's signals; ch_pt_ready[g] = core_pt_ready; all other ch_pt_ready are 0.
    - ch_ct_valid[g] = core_ct_valid; ch_ct_data and ch_ct_last pass through; core_ct_ready = ch_ct_ready[g]. Path is combinational, no added latency.
    - On core_done: go DONE.
  - DONE: ch_done[g]=1 for one cycle, ch_grant cleared, last_grant=g, go IDLE.
- Latency: ch_req seen in IDLE -> ch_grant next cycle -> core_start the following cycle.
- Context regs hold stable for the whole session; channel changes to ch_key, ch_nonce or ch_counter after grant are ignored.
- Minimum gap between sessions: 1 IDLE cycle.
- Requests: ch_req dropped before grant are ignored. ch_req still high in DONE gives that channel no preference; round-robin applies.
- A single requester may be re-granted consecutively if it is the only one requesting.
- A core_done arriving outside STREAM is ignored.
- Reset mid-session: immediate return to IDLE, all outputs 0. The core shares rst_n, so no drain is needed.
- Fairness: with all N_CH requesting continuously, grants cycle 0,1,..,N_CH-1,0.

Optional Feature:
CHACHA20_ARB_PRIORITY_EN
- Defined: channel 0 has strict priority. In IDLE, a pending ch_req[0] always wins; the remaining channels are round-robin among themselves.
- Undefined: pure round-robin as above.

Decomposition:
- Shared package/header: state encodings (IDLE, START, STREAM, DONE) and the default N_CH constant, added to chacha20_defs.
- Sub-module chacha20_rr_picker: combinational round-robin select (req vector, last_grant -> grant_idx, any_req); it also contains the priority override.

Test Plan:
- ch_req=4'b0001 with counter=1 and a 4-beat message -> grant 0001, core_start 2 cycles after req; ciphertext routed only to ch 0; ch_done[0] pulses 1 cycle.
- ch_req=4'b1111 held, 1-beat messages -> grant order 0,1,2,3,0.
- Ch 2 granted, ch_key[2] changed mid-stream -> core_key unchanged until DONE.
- Ch 1 streaming, ch_pt_valid[3]=1 -> ch_pt_ready[3]=0 throughout; ch_ct_ready[1]=0 for 5 cycles -> core_ct_ready=0 and the beat is held.
- rst_n low during STREAM -> all outputs 0; after release, ch_req=4'b1010 -> channel 1 is granted first.
- With CHACHA20_ARB_PRIORITY_EN, ch_req=4'b0011 repeatedly after each done -> channel 0 is always granted while requesting.

Source files
------------

// File: rtl/chacha20_defs.sv
// rtl/chacha20_defs.sv - shared definitions for the chacha20 session arbiter
package chacha20_defs;

    localparam int N_CH_DEFAULT = 4;
    localparam int WORD_W       = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    // Channel index reached by stepping 'step' places after 'base', wrapping at n
    function automatic int wrap_idx(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/chacha20_rr_picker.sv
// rtl/chacha20_rr_picker.sv - round-robin channel picker (CHACHA20_ARB_PRIORITY_EN: channel 0 strict priority)
module chacha20_rr_picker
    import chacha20_defs::*;
#(
    parameter int N_CH  = N_CH_DEFAULT,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any_req
);

    logic [N_CH-1:0]  w_req_rr;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

`ifdef CHACHA20_ARB_PRIORITY_EN
    // Channel 0 is taken out of the rotation and wins outright whenever it asks
    assign w_req_rr    = i_req & ~N_CH'(1);
    assign o_grant_idx = i_req[0] ? '0 : w_pick;
`else
    assign w_req_rr    = i_req;
    assign o_grant_idx = w_pick;
`endif

    assign o_any_req = |i_req;

    // Scan from the channel after the last one served, first requester wins
    always_comb begin
        w_pick  = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            w_cand = IDX_W'(wrap_idx(int'(i_last_grant), k, N_CH));
            if (!w_found && w_req_rr[w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chacha20_session_arbiter.sv
// rtl/chacha20_session_arbiter.sv - shares one chacha20 core between channels (CHACHA20_ARB_PRIORITY_EN: channel 0 priority)
module chacha20_session_arbiter
    import chacha20_defs::*;
#(
    parameter int N_CH             = N_CH_DEFAULT,
    parameter int DATA_WIDTH_WORDS = 1,
    parameter int IDX_W            = $clog2(N_CH)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_CH-1:0]                     ch_req,
    input  logic [N_CH*256-1:0]                 ch_key,
    input  logic [N_CH*96-1:0]                  ch_nonce,
    input  logic [N_CH*32-1:0]                  ch_counter,
    input  logic [N_CH*32*DATA_WIDTH_WORDS-1:0] ch_pt_data,
    input  logic [N_CH-1:0]                     ch_pt_valid,
    input  logic [N_CH-1:0]                     ch_pt_last,
    output logic [N_CH-1:0]                     ch_pt_ready,
    output logic [32*DATA_WIDTH_WORDS-1:0]      ch_ct_data,
    output logic [N_CH-1:0]                     ch_ct_valid,
    output logic                                ch_ct_last,
    input  logic [N_CH-1:0]                     ch_ct_ready,
    output logic [N_CH-1:0]                     ch_grant,
    output logic [N_CH-1:0]                     ch_done,
    output logic                                core_start,
    output logic [255:0]                        core_key,
    output logic [95:0]                         core_nonce,
    output logic [31:0]                         core_counter,
    output logic [32*DATA_WIDTH_WORDS-1:0]      core_pt_data,
    output logic                                core_pt_valid,
    output logic                                core_pt_last,
    input  logic                                core_pt_ready,
    input  logic [32*DATA_WIDTH_WORDS-1:0]      core_ct_data,
    input  logic                                core_ct_valid,
    input  logic                                core_ct_last,
    output logic                                core_ct_ready,
    input  logic                                core_done
);

    localparam int DW = WORD_W * DATA_WIDTH_WORDS;

    arb_state_e       r_state;
    arb_state_e       w_next_state;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_any_req;
    logic [255:0]     r_key;
    logic [95:0]      r_nonce;
    logic [31:0]      r_counter;
    logic             r_core_start;
    logic [N_CH-1:0]  w_grant_oh;

    chacha20_rr_picker #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req        (ch_req),
        .i_last_grant (r_last_grant),
        .o_grant_idx  (w_pick_idx),
        .o_any_req    (w_any_req)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: one whole message per grant; core_done only counts while streaming
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = START;
            START:   w_next_state = STREAM;
            STREAM:  if (core_done) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Grant index, session context and the start pulse. Context is captured once at
    // grant so later front-end changes cannot disturb a running session; the start
    // pulse leaves a flop the cycle after START, one cycle behind the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_idx  <= '0;
            r_last_grant <= IDX_W'(N_CH - 1);
            r_key        <= '0;
            r_nonce      <= '0;
            r_counter    <= '0;
            r_core_start <= 1'b0;
        end else begin
            r_core_start <= (r_state == START);
            if (r_state == IDLE && w_any_req) begin
                r_grant_idx <= w_pick_idx;
                r_key       <= ch_key[w_pick_idx*256 +: 256];
                r_nonce     <= ch_nonce[w_pick_idx*96 +: 96];
                r_counter   <= ch_counter[w_pick_idx*32 +: 32];
            end
            if (r_state == DONE) begin
                r_last_grant <= r_grant_idx;
            end
        end
    end

    assign w_grant_oh   = N_CH'(1) << r_grant_idx;
    assign core_start   = r_core_start;
    assign core_key     = r_key;
    assign core_nonce   = r_nonce;
    assign core_counter = r_counter;

    // Outputs: stream paths are routed only while streaming, everything else idles at 0
    always_comb begin
        ch_grant      = '0;
        ch_done       = '0;
        ch_pt_ready   = '0;
        ch_ct_valid   = '0;
        ch_ct_data    = '0;
        ch_ct_last    = 1'b0;
        core_pt_data  = '0;
        core_pt_valid = 1'b0;
        core_pt_last  = 1'b0;
        core_ct_ready = 1'b0;
        case (r_state)
            START: ch_grant = w_grant_oh;
            STREAM: begin
                ch_grant      = w_grant_oh;
                core_pt_data  = ch_pt_data[r_grant_idx*DW +: DW];
                core_pt_valid = ch_pt_valid[r_grant_idx];
                core_pt_last  = ch_pt_last[r_grant_idx];
                ch_pt_ready   = core_pt_ready ? w_grant_oh : '0;
                ch_ct_valid   = core_ct_valid ? w_grant_oh : '0;
                ch_ct_data    = core_ct_data;
                ch_ct_last    = core_ct_last;
                core_ct_ready = ch_ct_ready[r_grant_idx];
            end
            DONE:    ch_done = w_grant_oh;
            default: ;
        endcase
    end

endmodule
